alu_logic_pipe: RTL and testbench



---
 rtl/alu_logic_pkg.sv | 13 +
 rtl/alu_logic_pipe_stage.sv | 42 ++++
 rtl/alu_logic_pipe.sv | 126 ++++++++++++
 tb/tb_alu_logic_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_pkg.sv
// Shared types for the bitwise-logic pipeline: operation encoding and its width.
package alu_logic_pkg;

    localparam int LOGIC_OP_WIDTH = 2;

    typedef enum logic [LOGIC_OP_WIDTH-1:0] {
        LOGIC_AND = 2'b00,
        LOGIC_OR  = 2'b01,
        LOGIC_XOR = 2'b10,
        LOGIC_NOR = 2'b11
    } logic_op_e;

endpackage

// File: rtl/alu_logic_pipe_stage.sv
// Generic valid/ready register slice with synchronous clear; holds its payload while stalled.
module alu_logic_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             adv;

    // The slice may load whenever it is empty or its content leaves this cycle;
    // in_ready never looks at in_valid, so no valid->ready path exists.
    assign adv      = !valid_q || out_ready;
    assign in_ready = adv && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (adv) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready pipeline feeding the AND/OR/XOR/NOR ops; result and tag are registered.
// Optional performance counters are built when ALU_LOGIC_PIPE_PERF_EN is defined.
module alu_logic_pipe
    import alu_logic_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [LOGIC_OP_WIDTH-1:0] req_op,
    input  logic [OPERAND_WIDTH-1:0]  req_lhs,
    input  logic [OPERAND_WIDTH-1:0]  req_rhs,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [OPERAND_WIDTH-1:0]  rsp_result,
`ifdef ALU_LOGIC_PIPE_PERF_EN
    output logic [31:0]               perf_ops,
    output logic [31:0]               perf_stalls,
`endif
    output logic [TAG_WIDTH-1:0]      rsp_tag
);

    typedef struct packed {
        logic_op_e                op;
        logic [OPERAND_WIDTH-1:0] lhs;
        logic [OPERAND_WIDTH-1:0] rhs;
        logic [TAG_WIDTH-1:0]     tag;
    } logic_req_t;

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0] result;
        logic [TAG_WIDTH-1:0]     tag;
    } logic_rsp_t;

    logic_req_t               req_in;
    logic_req_t               s1;
    logic_rsp_t               s2_in;
    logic_rsp_t               s2;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s2_in_ready;
    logic [OPERAND_WIDTH-1:0] and_res;
    logic [OPERAND_WIDTH-1:0] or_res;
    logic [OPERAND_WIDTH-1:0] xor_res;
    logic [OPERAND_WIDTH-1:0] nor_res;
    logic [OPERAND_WIDTH-1:0] sel_res;

    // Handshake: a transfer happens on an edge where valid && ready; a producer holding
    // valid must keep its payload stable until that edge, and ready never depends on valid.
    assign req_in = '{op: logic_op_e'(req_op), lhs: req_lhs, rhs: req_rhs, tag: req_tag};

    alu_logic_pipe_stage #(.WIDTH($bits(logic_req_t))) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (req_valid),
        .in_ready (req_ready),
        .in_data  (req_in),
        .out_valid(s1_valid),
        .out_ready(s2_in_ready),
        .out_data (s1)
    );

    assign and_res = s1.lhs & s1.rhs;
    assign or_res  = s1.lhs | s1.rhs;
    assign xor_res = s1.lhs ^ s1.rhs;
    assign nor_res = ~or_res;

    always_comb begin
        sel_res = and_res;
        case (s1.op)
            LOGIC_AND: sel_res = and_res;
            LOGIC_OR:  sel_res = or_res;
            LOGIC_XOR: sel_res = xor_res;
            LOGIC_NOR: sel_res = nor_res;
            default:   sel_res = and_res;
        endcase
    end

    assign s2_in = '{result: sel_res, tag: s1.tag};

    alu_logic_pipe_stage #(.WIDTH($bits(logic_rsp_t))) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (s1_valid),
        .in_ready (s2_in_ready),
        .in_data  (s2_in),
        .out_valid(s2_valid),
        .out_ready(rsp_ready),
        .out_data (s2)
    );

    assign rsp_valid  = s2_valid;
    assign rsp_result = s2.result;
    assign rsp_tag    = s2.tag;

`ifdef ALU_LOGIC_PIPE_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stalls_q;

    // Counters saturate rather than wrap and ignore flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q    <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (perf_ops_q != 32'hFFFF_FFFF)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (rsp_valid && !rsp_ready && (perf_stalls_q != 32'hFFFF_FFFF)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench for alu_logic_pipe (8-bit operands, 4-bit tags) with a response scoreboard.
module tb_alu_logic_pipe;

    localparam int OW = 8;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [OW-1:0] req_lhs;
    logic [OW-1:0] req_rhs;
    logic [TW-1:0] req_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [OW-1:0] rsp_result;
    logic [TW-1:0] rsp_tag;
`ifdef ALU_LOGIC_PIPE_PERF_EN
    logic [31:0]   perf_ops;
    logic [31:0]   perf_stalls;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_lat  = 1'b0;
    bit hold     = 1'b0;
    bit rnd_done = 1'b0;
    logic [OW+TW-1:0] held_rsp;

    logic [OW+TW-1:0] exp_q[$];
    int               lat_q[$];

    alu_logic_pipe #(.OPERAND_WIDTH(OW), .TAG_WIDTH(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_lhs   (req_lhs),
        .req_rhs   (req_rhs),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
`ifdef ALU_LOGIC_PIPE_PERF_EN
        .perf_ops  (perf_ops),
        .perf_stalls(perf_stalls),
`endif
        .rsp_tag   (rsp_tag)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [1:0] op, input logic [OW-1:0] a,
                                            input logic [OW-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Scoreboard: samples on the falling edge, i.e. the values that the next rising edge uses.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            lat_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", {31'd0, rsp_valid}, 32'd1);
                check("stall_data", {20'd0, rsp_result, rsp_tag}, {20'd0, held_rsp});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {20'd0, rsp_result, rsp_tag}, 32'hFFFF_FFFF);
                end else begin
                    int l;
                    check("rsp_data", {20'd0, rsp_result, rsp_tag}, {20'd0, exp_q.pop_front()});
                    l = lat_q.pop_front();
                    if (chk_lat) check("latency", cyc - l, 32'd2);
                end
            end
            if (flush) begin
                exp_q.delete();
                lat_q.delete();
            end else if (req_valid && req_ready) begin
                exp_q.push_back({model(req_op, req_lhs, req_rhs), req_tag});
                lat_q.push_back(cyc);
            end
            hold     = rsp_valid && !rsp_ready && !flush;
            held_rsp = {rsp_result, rsp_tag};
        end
    end

    // Driver tasks: called just after a rising edge, return just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic [TW-1:0] tag);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_lhs   = a;
        req_rhs   = b;
        req_tag   = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_lhs   = 8'($urandom_range(0, 255));
        req_rhs   = 8'($urandom_range(0, 255));
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", exp_q.size(), 32'd0);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_lhs   = '0;
        req_rhs   = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
        check("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic ops back-to-back with the latency check enabled
        chk_lat = 1'b1;
        send(2'd1, 8'hA5, 8'h0F, 4'd1);
        send(2'd0, 8'hA5, 8'h0F, 4'd2);
        send(2'd2, 8'hA5, 8'h0F, 4'd3);
        send(2'd3, 8'hA5, 8'h0F, 4'd4);
        drain();
        chk_lat = 1'b0;

        // Backpressure: consumer stalls for cycles 3..7 of a 6-op stream
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), 4'(i + 8));
            end
            begin
                idle(3);
                rsp_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_req_ready", {31'd0, req_ready}, 32'd0);
                check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                idle(3);
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Bubble collapse: s2 stalled, s1 empty
        rsp_ready = 1'b0;
        send(2'd2, 8'h3C, 8'hFF, 4'd5);
        idle(2);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_lhs   = 8'h12;
        req_rhs   = 8'h40;
        req_tag   = 4'd6;
        @(negedge clk);
        check("bubble_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_tag = 4'd7;
        @(negedge clk);
        check("bubble_full", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Flush with two ops in flight and a request offered alongside
        rsp_ready = 1'b0;
        send(2'd0, 8'hF0, 8'h3C, 4'd9);
        send(2'd3, 8'h01, 8'h02, 4'd10);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_lhs   = 8'h55;
        req_rhs   = 8'hFF;
        req_tag   = 4'd11;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("flush_ready_back", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        chk_lat   = 1'b1;
        send(2'd1, 8'h81, 8'h18, 4'd12);
        drain();
        chk_lat = 1'b0;
        idle(4);
        check("flush_no_extra", exp_q.size(), 32'd0);

        // Random traffic with random consumer stalls and idle gaps
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
                    idle($urandom_range(0, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        // Reset mid-stream with both stages valid
        rsp_ready = 1'b0;
        send(2'd1, 8'hA5, 8'h0F, 4'd5);
        send(2'd2, 8'hA5, 8'h0F, 4'd6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_result", {24'd0, rsp_result}, 32'd0);
        check("mid_rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
`ifdef ALU_LOGIC_PIPE_PERF_EN
        check("mid_rst_perf_ops", perf_ops, 32'd0);
        check("mid_rst_perf_stalls", perf_stalls, 32'd0);
`endif
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

`ifdef ALU_LOGIC_PIPE_PERF_EN
        dut.perf_ops_q = 32'hFFFF_FFFE;
        send(2'd0, 8'h11, 8'h22, 4'd1);
        send(2'd1, 8'h11, 8'h22, 4'd2);
        send(2'd2, 8'h11, 8'h22, 4'd3);
        drain();
        @(negedge clk);
        check("perf_ops_sat", perf_ops, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
`endif

        idle(3);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
